irq_gateway: RTL

Interrupt-source conditioning stage that sits directly upstream of `plic` and drives its `ext_irq_src` bus. It synchronises raw peripheral interrupt lines, applies per-source polarity, and converts each source to either a level or a counted-edge request. Software configures and acknowledges it through a memory-mapped register slave on the standard `mem_if` request/response channel.

---
 rtl/irq_gateway.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/irq_gateway.sv
// irq_gateway: conditions raw peripheral interrupt lines for the PLIC external source bus.
//
// Each source is double-flopped, polarity adjusted, then presented either as a level or as an
// edge-counted request. Software reaches the configuration through a single-outstanding
// memory-mapped register slave. The mem_if request/response structs are carried as flat fields.
//
// Optional feature macro: IRQ_GATE_CNT_EN
//   defined   - each edge-mode source keeps a saturating CNT_W-bit event counter
//   undefined - each edge-mode source keeps a single pending bit
//
// Ports:
//   clk, rstn       clock and asynchronous active-low reset
//   mem_req_valid   request valid               mem_req_ready   request ready (idle)
//   mem_req_addr    byte address (idx [5:2])    mem_req_data    write data
//   mem_req_mask    write byte mask             mem_req_type    0 = MEM_READ, 1 = MEM_WRITE
//   mem_resp_valid  response valid              mem_resp_ready  response ready
//   mem_resp_data   read data (captured at accept)
//   mem_resp_last   mirrors mem_resp_valid
//   irq_in          raw asynchronous interrupt lines
//   irq_out         conditioned requests towards plic.ext_irq_src
//
// Register map (index = addr[5:2]):
//   0 MODE (RW, 1 = edge)  1 POL (RW, 1 = active-low)  2 ACK (WO, reads 0)
//   3 STATUS (RO, irq_out) 4 RAW (RO, synced irq_in)   5 CNT_SEL (RW)  6 CNT (RO)
module irq_gateway #(
  parameter int unsigned IRQ_N      = 32,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MEM_ADDR_W = 32,
  parameter int unsigned MEM_DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mem_req_valid,
  output logic                    mem_req_ready,
  input  logic [MEM_ADDR_W-1:0]   mem_req_addr,
  input  logic [MEM_DATA_W-1:0]   mem_req_data,
  input  logic [MEM_DATA_W/8-1:0] mem_req_mask,
  input  logic                    mem_req_type,
  output logic                    mem_resp_valid,
  input  logic                    mem_resp_ready,
  output logic [MEM_DATA_W-1:0]   mem_resp_data,
  output logic                    mem_resp_last,
  input  logic [IRQ_N-1:0]        irq_in,
  output logic [IRQ_N-1:0]        irq_out
);

  localparam logic MemWrite = 1'b1;
  localparam int unsigned SelW  = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam int unsigned StrbW = MEM_DATA_W / 8;

`ifdef IRQ_GATE_CNT_EN
  localparam int unsigned CntBits = CNT_W;
`else
  // Edge tracking collapses to one pending bit; CNT_W only sizes the counting build.
  localparam int unsigned CntBits = 1;
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

  localparam logic [3:0] RegMode   = 4'd0;
  localparam logic [3:0] RegPol    = 4'd1;
  localparam logic [3:0] RegAck    = 4'd2;
  localparam logic [3:0] RegStatus = 4'd3;
  localparam logic [3:0] RegRaw    = 4'd4;
  localparam logic [3:0] RegCntSel = 4'd5;
  localparam logic [3:0] RegCnt    = 4'd6;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e state_q, state_d;

  logic [IRQ_N-1:0]      sync1_q, sync2_q;
  logic [IRQ_N-1:0]      a_prev_q, a_prev_d;
  logic [IRQ_N-1:0]      mode_q, mode_d;
  logic [IRQ_N-1:0]      pol_q, pol_d;
  logic [IRQ_N-1:0]      adj, ack, cfg_chg, edge_det;
  logic [SelW-1:0]       cnt_sel_q, cnt_sel_d;
  logic [CntBits-1:0]    cnt_q [IRQ_N];
  logic [CntBits-1:0]    cnt_d [IRQ_N];
  logic [CntBits-1:0]    cnt_rd;
  logic [MEM_DATA_W-1:0] bmask, wdata, rd_val, rdata_q, rdata_d;
  logic [3:0]            reg_idx;
  logic                  accept, wr_en, rd_en;
  logic                  unused_addr;

  // ---------------------------------------------------------------------------
  // Slave handshake FSM: one transaction in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (mem_req_valid)  state_d = StResp;
      StResp: if (mem_resp_ready) state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req_ready  = (state_q == StIdle);
    mem_resp_valid = (state_q == StResp);
    mem_resp_last  = (state_q == StResp);
  end

  assign accept      = mem_req_valid & mem_req_ready;
  assign wr_en       = accept & (mem_req_type == MemWrite);
  assign rd_en       = accept & (mem_req_type != MemWrite);
  assign reg_idx     = mem_req_addr[5:2];
  assign unused_addr = ^{mem_req_addr[MEM_ADDR_W-1:6], mem_req_addr[1:0]};

  always_comb begin
    bmask = '0;
    for (int b = 0; b < StrbW; b++) begin
      bmask[8*b +: 8] = {8{mem_req_mask[b]}};
    end
  end

  assign wdata = mem_req_data & bmask;

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d    = mode_q;
    pol_d     = pol_q;
    cnt_sel_d = cnt_sel_q;
    ack       = '0;
    if (wr_en) begin
      case (reg_idx)
        RegMode:   mode_d    = (mode_q & ~bmask[IRQ_N-1:0]) | wdata[IRQ_N-1:0];
        RegPol:    pol_d     = (pol_q & ~bmask[IRQ_N-1:0]) | wdata[IRQ_N-1:0];
        RegAck:    ack       = wdata[IRQ_N-1:0];
        RegCntSel: cnt_sel_d = (cnt_sel_q & ~bmask[SelW-1:0]) | wdata[SelW-1:0];
        default:   ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-source conditioning
  // ---------------------------------------------------------------------------
  assign adj     = sync2_q ^ pol_q;
  assign cfg_chg = (mode_d ^ mode_q) | (pol_d ^ pol_q);

  // Tracking the new-polarity value also covers reconfigured bits: a_prev is loaded with the
  // freshly adjusted level, so a POL flip never looks like an edge.
  assign a_prev_d = sync2_q ^ pol_d;

  assign edge_det = adj & ~a_prev_q & mode_q & ~cfg_chg;

  always_comb begin
    for (int i = 0; i < IRQ_N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cfg_chg[i] || !mode_q[i]) begin
        cnt_d[i] = '0;
`ifdef IRQ_GATE_CNT_EN
      end else if (edge_det[i] && !ack[i]) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CntBits'(1);
      end else if (ack[i] && !edge_det[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntBits'(1);
      end
`else
      end else begin
        // Edge wins over a simultaneous ACK so a fresh event is never lost.
        cnt_d[i] = edge_det[i] | (cnt_q[i] & ~ack[i]);
      end
`endif
    end
  end

  always_comb begin
    for (int i = 0; i < IRQ_N; i++) begin
      irq_out[i] = mode_q[i] ? (cnt_q[i] != '0) : adj[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: data is snapshotted at the accept edge
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < IRQ_N; i++) begin
      if (cnt_sel_q == SelW'(i)) cnt_rd = cnt_q[i];
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      RegMode:   rd_val[IRQ_N-1:0]   = mode_q;
      RegPol:    rd_val[IRQ_N-1:0]   = pol_q;
      RegStatus: rd_val[IRQ_N-1:0]   = irq_out;
      RegRaw:    rd_val[IRQ_N-1:0]   = sync2_q;
      RegCntSel: rd_val[SelW-1:0]    = cnt_sel_q;
      RegCnt:    rd_val[CntBits-1:0] = cnt_rd;
      default:   ;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept) rdata_d = rd_en ? rd_val : '0;
  end

  assign mem_resp_data = rdata_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      a_prev_q  <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      cnt_sel_q <= '0;
      rdata_q   <= '0;
      for (int i = 0; i < IRQ_N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      a_prev_q  <= a_prev_d;
      mode_q    <= mode_d;
      pol_q     <= pol_d;
      cnt_sel_q <= cnt_sel_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < IRQ_N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
